simd_acc_collector: RTL and testbench
=====================================

# simd_acc_collector

- Downstream stage of the 64-lane SIMD MAC array and its adder tree.
- Runs a delay line that carries the valid and control bits for each operand beat issued into the array. When the tree results arrive, it accumulates them across several beats into one group, so dot products can be longer than 64.
- Each finished group goes into a 2-entry output buffer read out through a valid/ready handshake.
- Issue is credit-limited, so results in flight are never lost.

## Interface
Parameters:
- MAC_BW, default `MAC_BW: operand width; adder-tree outputs are 2*MAC_BW.
- ACC_BW, default 2*MAC_BW+8: accumulator width per lane.
- LAT, default 4: cycles from an operand beat at the array inputs to its results on iL1/iL2/iL3; must be ≥1.

Ports:
- clk  in  1: clock, rising edge.
- rst_n  in  1: synchronous, active-low reset.
- issue_valid  in  1: an operand beat is presented to the array this cycle.
- issue_ready  out  1: a beat may be issued.
- issue_last  in  1: this beat closes the current group.
- issue_lvl  in  2: tree level to collect. 0 = L1 (16 lanes), 1 = L2 (4 lanes), 2 and 3 = L3 (1 lane).
- iL1  in  16×(2*MAC_BW): tree level-1 sums.
- iL2  in  4×(2*MAC_BW): tree level-2 sums.
- iL3  in  2*MAC_BW: tree level-3 sum.
- o_valid  out  1: the head of the output buffer is valid.
- o_ready  in  1: downstream accepts the head.
- o_data  out  16×ACC_BW: accumulated lanes; unused lanes are 0.
- o_lvl  out  2: group level, normalised to 0, 1 or 2.
- o_ovf  out  1: signed overflow occurred in some lane during the group.

## Operation
- A beat is accepted when issue_valid && issue_ready.
- Delay line: LAT register stages, each holding {v, last, lvl}. Stage 0 loads the accepted beat; if no beat is accepted it loads v=0.
- Stage LAT-1 with v=1 marks the arrival of that beat's results on iL*. Results with v=0 are ignored.
- Group level is captured on the first beat of a group. The first beat is the first accepted beat after reset or after a last beat. issue_lvl on later beats is ignored.
- Lane inputs by level:
  - L1: lane k takes iL1[k].
  - L2: lanes 0..3 take iL2; lanes 4..15 take 0.
  - L3: lane 0 takes iL3; lanes 1..15 take 0.
- Inputs are signed and sign-extended to ACC_BW.
- acc_next = (first ? 0 : acc) + ext(in). On overflow the sum wraps modulo 2^ACC_BW.
- The sticky ovf bit is set if any lane's add overflows as a signed operation. It is cleared at the start of each group.
- Arrival with last=1:
  - {acc_next, lvl, ovf_next} is pushed into the output buffer.
  - The accumulator is marked "first" for the next beat.
- Output buffer: 2-entry FIFO. A push and a pop may happen in the same cycle.
- Credit: issue_ready = (fifo_count + number of delay stages holding v&last) < 2. This guarantees a push never meets a full buffer.
- A non-last beat does not consume credit.

## Timing
- Beat accepted at cycle t → accumulated on the clock edge ending cycle t+LAT.
- If the beat was last, o_valid=1 with its data from cycle t+LAT+1. Minimum end-to-end latency is therefore LAT+1.
- Back-to-back beats are accumulated every cycle; throughput is 1 beat per cycle.
- An output handshake completes in any cycle with o_valid && o_ready. Data under o_valid holds stable until popped.
- Reset (rst_n=0 sampled on an edge): takes effect synchronously and clears:
  - delay line v bits;
  - accumulators and ovf;
  - FIFO; the first flag is set.
- Output values while or after reset: o_valid=0, o_data=0, o_lvl=0, o_ovf=0.
- issue_ready is 0 while rst_n=0 and 1 in the first cycle after release.
- Reset mid-group: in-flight beats and partial sums are discarded with no output.
- issue_valid while issue_ready=0 is not accepted and has no effect.

## Structure
- simd_pkg holds:
  - the MAC_BW default;
  - the LAT default;
  - typedef lvl_e {LVL_L1, LVL_L2, LVL_L3};
  - the acc_lane_t width helper.
- Sub-module acc_out_fifo: 2-entry synchronous FIFO with valid/ready, parameterised by payload width. It holds {data, lvl, ovf}.
- The delay line, accumulators and credit counter are inline in simd_acc_collector.

## Test plan
- LAT=4, single-beat group at L1 with iL1[k]=k+1, last=1 → o_valid at t+5 with o_data[k]=k+1, o_lvl=0, o_ovf=0.
- 3-beat L2 group with iL2[j]=100 each beat; issue_lvl switched to 0 on beats 2–3 → lanes 0..3 = 300, lanes 4..15 = 0, o_lvl=1 (the switch is ignored).
- ACC_BW=18, MAC_BW=8, L3 beats of 0x7FFF repeated 5 times → o_data[0]=0x27FFB wrapped to 18 bits as signed, o_ovf=1; the next group gives o_ovf=0.
- o_ready held 0 while issuing single-beat last groups every cycle:
  - issue_ready falls after 2 accepted last beats;
  - exactly 2 entries are buffered;
  - after o_ready=1 the entries drain in order and issue_ready recovers.
- rst_n pulsed low for one cycle mid-group with 2 beats in flight → no output. The next group's result excludes the pre-reset sums, and all outputs are 0 during the reset cycle.
- Simultaneous push and pop with the FIFO holding 1 entry → count stays 1 and the ordering is preserved.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared defaults, level encoding and delay-line beat type for the
// SIMD accumulate/collect stage behind the MAC array adder tree.
package simd_pkg;
    localparam int MAC_BW_DEF = 8;
    localparam int LAT_DEF    = 4;
    localparam int LANES      = 16;

    typedef enum logic [1:0] {
        LVL_L1 = 2'd0,
        LVL_L2 = 2'd1,
        LVL_L3 = 2'd2
    } lvl_e;

    typedef struct packed {
        logic v;
        logic last;
        lvl_e lvl;
    } beat_t;

    // Accumulator lane width: adder-tree output plus 8 guard bits.
    function automatic int acc_lane_w(input int mac_bw);
        return 2 * mac_bw + 8;
    endfunction

    // Raw level codes 2 and 3 both select the single-lane L3 output.
    function automatic lvl_e norm_lvl(input logic [1:0] raw);
        case (raw)
            2'd0:    return LVL_L1;
            2'd1:    return LVL_L2;
            default: return LVL_L3;
        endcase
    endfunction
endpackage

// File: rtl/acc_out_fifo.sv
// Two-entry output buffer for finished groups; a push and a pop may
// happen in the same cycle. Data reads as zero while the buffer is empty.
module acc_out_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] mem_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         do_push;
    logic         do_pop;

    assign out_valid = (count_reg != 2'd0);
    assign do_pop    = out_valid && out_ready;
    assign do_push   = in_valid && ((count_reg != 2'd2) || do_pop);
    assign out_data  = out_valid ? mem_reg[rd_ptr_reg] : '0;
    assign count     = count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= in_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/simd_acc_collector.sv
// Collects adder-tree results behind the 64-lane MAC array: tracks issued
// beats through a delay line, accumulates groups and buffers finished ones.
module simd_acc_collector
    import simd_pkg::*;
#(
    parameter int MAC_BW = MAC_BW_DEF,
    parameter int ACC_BW = acc_lane_w(MAC_BW),
    parameter int LAT    = LAT_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                issue_valid,
    output logic                                issue_ready,
    input  logic                                issue_last,
    input  logic [1:0]                          issue_lvl,
    input  logic [LANES-1:0][2*MAC_BW-1:0]      iL1,
    input  logic [3:0][2*MAC_BW-1:0]            iL2,
    input  logic [2*MAC_BW-1:0]                 iL3,
    output logic                                o_valid,
    input  logic                                o_ready,
    output logic [LANES-1:0][ACC_BW-1:0]        o_data,
    output logic [1:0]                          o_lvl,
    output logic                                o_ovf
);
    localparam int IW = 2 * MAC_BW;
    localparam int PW = LANES * ACC_BW + 3;

    beat_t                          dl_reg [LAT];
    beat_t                          head;
    logic                           issue_first_reg;
    lvl_e                           grp_lvl_reg;
    lvl_e                           beat_lvl;
    logic [1:0]                     inflight_reg;
    logic [1:0]                     fifo_count;
    logic [2:0]                     credit_used;
    logic                           accept;
    logic                           arrive;
    logic                           arrive_last;
    logic                           first_reg;
    logic                           ovf_reg;
    logic                           ovf_next;
    logic [LANES-1:0][ACC_BW-1:0]   acc_reg;
    logic [LANES-1:0][ACC_BW-1:0]   acc_next;
    logic [LANES-1:0]               lane_ovf;
    logic [PW-1:0]                  push_data;
    logic [PW-1:0]                  fifo_out;
    logic                           fifo_valid;
    logic                           fifo_pop;

    // Every last beat in flight already owns a buffer slot, so a push never finds it full.
    assign credit_used = 3'(fifo_count) + 3'(inflight_reg);
    assign issue_ready = rst_n && (credit_used < 3'd2);
    assign accept      = issue_valid && issue_ready;

    // Level is frozen by the first beat of a group and carried with every beat.
    assign beat_lvl    = issue_first_reg ? norm_lvl(issue_lvl) : grp_lvl_reg;

    assign head        = dl_reg[LAT-1];
    assign arrive      = head.v;
    assign arrive_last = head.v && head.last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_first_reg <= 1'b1;
            grp_lvl_reg     <= LVL_L1;
            inflight_reg    <= 2'd0;
        end else begin
            if (accept) begin
                issue_first_reg <= issue_last;
                if (issue_first_reg) begin
                    grp_lvl_reg <= norm_lvl(issue_lvl);
                end
            end
            inflight_reg <= inflight_reg + 2'(accept && issue_last) - 2'(arrive_last);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                dl_reg[i] <= '0;
            end
        end else begin
            dl_reg[0] <= '{v: accept, last: accept && issue_last, lvl: beat_lvl};
            for (int i = 1; i < LAT; i++) begin
                dl_reg[i] <= dl_reg[i-1];
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [IW-1:0]     l2_in;
        logic [IW-1:0]     l3_in;
        logic [IW-1:0]     raw;
        logic [ACC_BW-1:0] lane_in;
        logic [ACC_BW-1:0] lane_base;

        if (gi < 4) begin : g_l2
            assign l2_in = iL2[gi];
        end else begin : g_l2_zero
            assign l2_in = '0;
        end

        if (gi == 0) begin : g_l3
            assign l3_in = iL3;
        end else begin : g_l3_zero
            assign l3_in = '0;
        end

        assign raw       = (head.lvl == LVL_L1) ? iL1[gi] :
                           (head.lvl == LVL_L2) ? l2_in : l3_in;
        assign lane_in   = {{(ACC_BW-IW){raw[IW-1]}}, raw};
        assign lane_base = first_reg ? '0 : acc_reg[gi];
        assign acc_next[gi] = lane_base + lane_in;
        // Signed overflow: operands agree in sign but the wrapped sum does not.
        assign lane_ovf[gi] = (lane_base[ACC_BW-1] == lane_in[ACC_BW-1]) &&
                              (acc_next[gi][ACC_BW-1] != lane_base[ACC_BW-1]);
    end

    assign ovf_next = (first_reg ? 1'b0 : ovf_reg) | (|lane_ovf);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            first_reg <= 1'b1;
        end else if (arrive) begin
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
            first_reg <= head.last;
        end
    end

    assign push_data = {acc_next, head.lvl, ovf_next};
    assign fifo_pop  = o_valid && o_ready;

    acc_out_fifo #(
        .W (PW)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (arrive_last),
        .in_data   (push_data),
        .out_valid (fifo_valid),
        .out_ready (fifo_pop),
        .out_data  (fifo_out),
        .count     (fifo_count)
    );

    // Outputs read as zero for as long as reset is asserted.
    assign o_valid = fifo_valid && rst_n;
    assign o_data  = rst_n ? fifo_out[PW-1:3] : '0;
    assign o_lvl   = rst_n ? fifo_out[2:1] : 2'd0;
    assign o_ovf   = rst_n && fifo_out[0];
endmodule

// File: tb/tb_simd_acc_collector.sv
// Bench for simd_acc_collector: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_simd_acc_collector;
    localparam int MAC_BW = 8;
    localparam int ACC_BW = 18;
    localparam int LAT    = 4;
    localparam int IW     = 2 * MAC_BW;
    localparam int AMAX   = 131071;
    localparam int AMIN   = -131072;
    localparam int AMOD   = 262144;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        issue_valid;
    logic                        issue_ready;
    logic                        issue_last;
    logic [1:0]                  issue_lvl;
    logic [15:0][IW-1:0]         iL1;
    logic [3:0][IW-1:0]          iL2;
    logic [IW-1:0]               iL3;
    logic                        o_valid;
    logic                        o_ready;
    logic [15:0][ACC_BW-1:0]     o_data;
    logic [1:0]                  o_lvl;
    logic                        o_ovf;

    always #5 clk = ~clk;

    simd_acc_collector #(
        .MAC_BW (MAC_BW),
        .ACC_BW (ACC_BW),
        .LAT    (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_last  (issue_last),
        .issue_lvl   (issue_lvl),
        .iL1         (iL1),
        .iL2         (iL2),
        .iL3         (iL3),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_lvl       (o_lvl),
        .o_ovf       (o_ovf)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_n(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [15:0][ACC_BW-1:0] act,
                         input logic [15:0][ACC_BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [15:0][ACC_BW-1:0] data;
        logic [1:0]              lvl;
        logic                    ovf;
    } exp_t;

    typedef struct packed {
        int         arr;
        logic       last;
        logic [1:0] lvl;
    } pend_t;

    exp_t       exp_q[$];
    pend_t      pend_q[$];
    int         cyc = 0;
    int         m_acc [16];
    bit         m_first = 1'b1;
    bit         m_ovf = 1'b0;
    bit         m_ifirst = 1'b1;
    logic [1:0] m_glvl = 2'd0;

    task automatic model_arrive(input pend_t p);
        exp_t e;
        bit   any;
        int   in_v;
        int   s;
        e   = '0;
        any = 1'b0;
        for (int k = 0; k < 16; k++) begin
            in_v = 0;
            if (p.lvl == 2'd0) in_v = int'($signed(iL1[k]));
            else if (p.lvl == 2'd1) begin
                if (k < 4) in_v = int'($signed(iL2[k]));
            end else if (k == 0) in_v = int'($signed(iL3));
            s = (m_first ? 0 : m_acc[k]) + in_v;
            if (s > AMAX) begin
                s -= AMOD;
                any = 1'b1;
            end else if (s < AMIN) begin
                s += AMOD;
                any = 1'b1;
            end
            m_acc[k]  = s;
            e.data[k] = 18'(s);
        end
        m_ovf   = (m_first ? 1'b0 : m_ovf) | any;
        m_first = p.last;
        if (p.last) begin
            e.lvl = p.lvl;
            e.ovf = m_ovf;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin : cmp
        int    inflight;
        bit    e_ready;
        bit    e_valid;
        exp_t  e;
        pend_t p;
        cyc++;
        if (!rst_n) begin
            chk_b("rst_issue_ready", issue_ready, 1'b0);
            chk_b("rst_o_valid", o_valid, 1'b0);
            chk_d("rst_o_data", o_data, '0);
            chk_n("rst_o_lvl", int'(o_lvl), 0);
            chk_b("rst_o_ovf", o_ovf, 1'b0);
            exp_q.delete();
            pend_q.delete();
            m_first  = 1'b1;
            m_ovf    = 1'b0;
            m_ifirst = 1'b1;
            for (int k = 0; k < 16; k++) m_acc[k] = 0;
        end else begin
            inflight = 0;
            foreach (pend_q[i]) if (pend_q[i].last) inflight++;
            e_ready = (exp_q.size() + inflight) < 2;
            e_valid = exp_q.size() != 0;
            chk_b("issue_ready", issue_ready, e_ready);
            chk_b("o_valid", o_valid, e_valid);
            if (e_valid) begin
                e = exp_q[0];
                chk_d("o_data", o_data, e.data);
                chk_n("o_lvl", int'(o_lvl), int'(e.lvl));
                chk_b("o_ovf", o_ovf, e.ovf);
                if (o_ready) void'(exp_q.pop_front());
            end
            if (pend_q.size() != 0 && pend_q[0].arr == cyc) begin
                p = pend_q.pop_front();
                model_arrive(p);
            end
            if (issue_valid && e_ready) begin
                if (m_ifirst) m_glvl = (issue_lvl >= 2'd2) ? 2'd2 : issue_lvl;
                m_ifirst = issue_last;
                p.arr  = cyc + LAT;
                p.last = issue_last;
                p.lvl  = m_glvl;
                pend_q.push_back(p);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic last, input logic [1:0] lvl);
        issue_valid = 1'b1;
        issue_last  = last;
        issue_lvl   = lvl;
        tick();
        issue_valid = 1'b0;
        issue_last  = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!o_valid && n < budget) begin
            tick();
            n++;
        end
        chk_b(name, o_valid, 1'b1);
    endtask

    initial begin
        logic [15:0][ACC_BW-1:0] ev;
        int acc_cnt;
        int npop;
        int pops [2];

        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        issue_lvl   = 2'd0;
        iL1         = '0;
        iL2         = '0;
        iL3         = '0;
        o_ready     = 1'b1;
        tick();
        tick();
        chk_b("reset_issue_ready", issue_ready, 1'b0);
        chk_b("reset_o_valid", o_valid, 1'b0);
        rst_n = 1'b1;
        #1;
        chk_b("ready_after_release", issue_ready, 1'b1);
        tick();

        // Single-beat L1 group, latency LAT+1.
        for (int k = 0; k < 16; k++) iL1[k] = 16'(k + 1);
        issue(1'b1, 2'd0);
        repeat (3) tick();
        chk_b("t1_not_early", o_valid, 1'b0);
        tick();
        chk_b("t1_valid_at_t5", o_valid, 1'b1);
        for (int k = 0; k < 16; k++) ev[k] = 18'(k + 1);
        chk_d("t1_data", o_data, ev);
        chk_n("t1_lvl", int'(o_lvl), 0);
        chk_b("t1_ovf", o_ovf, 1'b0);
        repeat (3) tick();

        // Three-beat L2 group; the later level change must be ignored.
        for (int k = 0; k < 16; k++) iL1[k] = 16'($urandom);
        for (int j = 0; j < 4; j++) iL2[j] = 16'd100;
        issue_valid = 1'b1;
        issue_last = 1'b0; issue_lvl = 2'd1; tick();
        issue_lvl = 2'd0; tick();
        issue_last = 1'b1; tick();
        issue_valid = 1'b0; issue_last = 1'b0;
        wait_valid("t2_timeout", 10);
        ev = '0;
        for (int j = 0; j < 4; j++) ev[j] = 18'd300;
        chk_d("t2_data", o_data, ev);
        chk_n("t2_lvl", int'(o_lvl), 1);
        chk_b("t2_ovf", o_ovf, 1'b0);
        repeat (3) tick();

        // Five L3 beats of 0x7FFF overflow the 18-bit lane.
        iL3 = 16'h7FFF;
        issue_valid = 1'b1; issue_lvl = 2'd2; issue_last = 1'b0;
        repeat (4) tick();
        issue_last = 1'b1; tick();
        issue_valid = 1'b0; issue_last = 1'b0;
        wait_valid("t3_timeout", 10);
        ev = '0;
        ev[0] = 18'h27FFB;
        chk_d("t3_data", o_data, ev);
        chk_n("t3_lvl", int'(o_lvl), 2);
        chk_b("t3_ovf", o_ovf, 1'b1);
        tick();
        iL3 = 16'd5;
        issue(1'b1, 2'd3);
        wait_valid("t3b_timeout", 10);
        ev[0] = 18'd5;
        chk_d("t3b_data", o_data, ev);
        chk_n("t3b_lvl", int'(o_lvl), 2);
        chk_b("t3b_ovf_cleared", o_ovf, 1'b0);
        repeat (3) tick();

        // Credit back-pressure with the output stalled.
        o_ready = 1'b0;
        issue_valid = 1'b1; issue_last = 1'b1; issue_lvl = 2'd0;
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            iL1[0] = 16'(100 + i);
            if (issue_ready) acc_cnt++;
            tick();
        end
        issue_valid = 1'b0; issue_last = 1'b0;
        chk_n("t4_accepted", acc_cnt, 2);
        chk_b("t4_ready_low", issue_ready, 1'b0);
        chk_b("t4_buffered", o_valid, 1'b1);
        o_ready = 1'b1;
        npop = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_valid) begin
                if (npop < 2) pops[npop] = int'(o_data[0]);
                npop++;
            end
            tick();
        end
        chk_n("t4_drain_count", npop, 2);
        chk_n("t4_first", pops[0], 104);
        chk_n("t4_second", pops[1], 105);
        chk_b("t4_ready_back", issue_ready, 1'b1);

        // Reset mid-group with a buffered result and two beats in flight.
        o_ready = 1'b0;
        for (int k = 0; k < 16; k++) iL1[k] = 16'd50;
        issue(1'b1, 2'd0);
        wait_valid("t5_pre_timeout", 10);
        issue_valid = 1'b1; issue_last = 1'b0; issue_lvl = 2'd0;
        tick(); tick();
        issue_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_b("t5_rst_valid", o_valid, 1'b0);
        chk_d("t5_rst_data", o_data, '0);
        chk_b("t5_rst_ready", issue_ready, 1'b0);
        for (int k = 0; k < 16; k++) iL1[k] = 16'd3;
        tick();
        rst_n = 1'b1;
        #1;
        chk_b("t5_flushed", o_valid, 1'b0);
        o_ready = 1'b1;
        issue(1'b1, 2'd0);
        wait_valid("t5_timeout", 10);
        for (int k = 0; k < 16; k++) ev[k] = 18'd3;
        chk_d("t5_data", o_data, ev);
        repeat (3) tick();

        // Push and pop in the same cycle with one entry held.
        o_ready = 1'b0;
        iL1[0] = 16'd7;
        issue(1'b1, 2'd0);
        repeat (5) tick();
        iL1[0] = 16'd9;
        issue(1'b1, 2'd0);
        repeat (3) tick();
        chk_b("t6_head_valid", o_valid, 1'b1);
        chk_n("t6_head_a", int'(o_data[0]), 7);
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        chk_b("t6_still_valid", o_valid, 1'b1);
        chk_n("t6_head_b", int'(o_data[0]), 9);
        o_ready = 1'b1;
        tick();
        chk_b("t6_empty", o_valid, 1'b0);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 600; i++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_last  = ($urandom_range(0, 2) == 0);
            issue_lvl   = 2'($urandom);
            for (int k = 0; k < 16; k++) iL1[k] = 16'($urandom);
            for (int j = 0; j < 4; j++) iL2[j] = 16'($urandom);
            iL3     = 16'($urandom);
            o_ready = ($urandom_range(0, 3) != 0);
            rst_n   = ($urandom_range(0, 149) != 0);
            tick();
        end
        rst_n = 1'b1;
        issue_valid = 1'b0;
        o_ready = 1'b1;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
